// File: rtl/pipe_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_types_pkg
// Brief    : Shared types and defaults for the pipeline hazard controller.
// Revision : 1.0
// ============================================================================
package pipe_types_pkg;

  localparam int c_REGW_DEFAULT = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    LUSE  = 2'd2,
    REDIR = 2'd3
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hz_raw_detect.sv
`default_nettype none
// ============================================================================
// Module   : hz_raw_detect
// Brief    : Combinational source/destination match for RAW hazards in ID.
// Revision : 1.0
// ============================================================================
module hz_raw_detect
  import pipe_types_pkg::*;
#(
  parameter int REGW   = c_REGW_DEFAULT,
  parameter int FWD_EN = 1
) (
  input  logic            idex_memread,
  input  logic [REGW-1:0] idex_rd,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_regwr,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_regwr,
  output logic            raw_hazard
);

  logic w_idex_hit;
  logic w_exmem_hit;
  logic w_memwb_hit;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  assign w_idex_hit  = (idex_rd != '0) &&
                       ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
  assign w_exmem_hit = exmem_regwr && (exmem_rd != '0) &&
                       ((exmem_rd == ifid_rs) || (exmem_rd == ifid_rt));
  assign w_memwb_hit = memwb_regwr && (memwb_rd != '0) &&
                       ((memwb_rd == ifid_rs) || (memwb_rd == ifid_rt));

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Forwarding covers everything except a load whose data is not yet read.
      logic w_unused_ok;
      assign raw_hazard  = idex_memread & w_idex_hit;
      assign w_unused_ok = w_exmem_hit ^ w_memwb_hit;
    end else begin : g_nofwd
      // ID/EX carries no write enable, so any nonzero destination is a producer.
      logic w_unused_ok;
      assign raw_hazard  = w_idex_hit | w_exmem_hit | w_memwb_hit;
      assign w_unused_ok = idex_memread;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush controller for a classic in-order pipeline.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl
  import pipe_types_pkg::*;
#(
  parameter int NLATCH = 4,
  parameter int REGW   = c_REGW_DEFAULT,
  parameter int FWD_EN = 1,
  parameter int CNTW   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              dhit,
  input  logic              redirect,
  input  logic              idex_memread,
  input  logic [REGW-1:0]   idex_rd,
  input  logic [REGW-1:0]   ifid_rs,
  input  logic [REGW-1:0]   ifid_rt,
  input  logic [REGW-1:0]   exmem_rd,
  input  logic [REGW-1:0]   memwb_rd,
  input  logic              exmem_regwr,
  input  logic              memwb_regwr,
  output logic              pc_stall,
  output logic [NLATCH-1:0] stall,
  output logic [NLATCH-1:0] flush,
  output logic [1:0]        state,
  output logic [CNTW-1:0]   stall_cnt
);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic              r_pend_redir;
  logic              w_pend_nxt;
  logic [CNTW-1:0]   r_stall_cnt;
  logic              w_raw_hazard;
  logic              w_dwait;
  logic              w_redir_req;
  logic              w_lu_en;
  logic              w_pc_stall;
  logic [NLATCH-1:0] w_stall;
  logic [NLATCH-1:0] w_flush;

  hz_raw_detect #(
    .REGW   (REGW),
    .FWD_EN (FWD_EN)
  ) u_raw_detect (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .exmem_rd     (exmem_rd),
    .exmem_regwr  (exmem_regwr),
    .memwb_rd     (memwb_rd),
    .memwb_regwr  (memwb_regwr),
    .raw_hazard   (w_raw_hazard)
  );

  assign w_dwait     = (dmemREN | dmemWEN) & ~dhit;
  assign w_redir_req = redirect | r_pend_redir;
  // The bubble inserted for a load-use must not re-trigger the same stall.
  assign w_lu_en     = (r_state != LUSE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= RUN;
      r_pend_redir <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_redir <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_redir;
    w_pc_stall  = 1'b0;
    w_stall     = '0;
    w_flush     = '0;
    case (r_state)
      REDIR: begin
        w_flush[0] = 1'b1;
        if (ihit) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        // RUN, LUSE and the DWAIT exit share one prioritised evaluation.
        if (w_dwait) begin
          w_pc_stall  = 1'b1;
          w_stall     = '1;
          w_pend_nxt  = w_redir_req;
          w_state_nxt = DWAIT;
        end else if (w_redir_req) begin
          w_flush[1:0] = 2'b11;
          w_pend_nxt   = 1'b0;
          w_state_nxt  = REDIR;
        end else if (w_raw_hazard && w_lu_en) begin
          w_pc_stall  = 1'b1;
          w_stall[0]  = 1'b1;
          w_flush[1]  = 1'b1;
          w_state_nxt = (FWD_EN != 0) ? LUSE : RUN;
        end else if (!ihit) begin
          w_pc_stall  = 1'b1;
          w_stall[0]  = 1'b1;
          w_flush[1]  = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (w_pc_stall && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  // Reset bubbles every latch and releases all holds.
  assign pc_stall  = RST ? 1'b0 : w_pc_stall;
  assign stall     = RST ? '0   : w_stall;
  assign flush     = RST ? '1   : w_flush;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
  import pipe_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dmemREN, dmemWEN, dhit, redirect, idex_memread;
  logic [4:0] idex_rd, ifid_rs, ifid_rt, exmem_rd, memwb_rd;
  logic       exmem_regwr, memwb_regwr;

  logic        pc_a, pc_n, pc_c;
  logic [3:0]  stall_a, stall_n, stall_c, flush_a, flush_n, flush_c;
  logic [1:0]  state_a, state_n, state_c;
  logic [15:0] cnt_a, cnt_n;
  logic [3:0]  cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.NLATCH(4), .REGW(5), .FWD_EN(1), .CNTW(16)) dut_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dhit(dhit), .redirect(redirect), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwr(exmem_regwr),
    .memwb_regwr(memwb_regwr), .pc_stall(pc_a), .stall(stall_a),
    .flush(flush_a), .state(state_a), .stall_cnt(cnt_a));

  pipe_hazard_ctrl #(.NLATCH(4), .REGW(5), .FWD_EN(0), .CNTW(16)) dut_n (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dhit(dhit), .redirect(redirect), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwr(exmem_regwr),
    .memwb_regwr(memwb_regwr), .pc_stall(pc_n), .stall(stall_n),
    .flush(flush_n), .state(state_n), .stall_cnt(cnt_n));

  pipe_hazard_ctrl #(.NLATCH(4), .REGW(5), .FWD_EN(1), .CNTW(4)) dut_c (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dhit(dhit), .redirect(redirect), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwr(exmem_regwr),
    .memwb_regwr(memwb_regwr), .pc_stall(pc_c), .stall(stall_c),
    .flush(flush_c), .state(state_c), .stall_cnt(cnt_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; dhit = 1'b0; redirect = 1'b0;
    idex_memread = 1'b0; idex_rd = '0; ifid_rs = '0; ifid_rt = '0;
    exmem_rd = '0; memwb_rd = '0; exmem_regwr = 1'b0; memwb_regwr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check_eq("rst_stall",    stall_a, 4'h0);
    check_eq("rst_flush",    flush_a, 4'hF);
    check_eq("rst_pc_stall", pc_a,    1'b0);
    check_eq("rst_state",    state_a, 2'd0);
    check_eq("rst_cnt",      cnt_a,   16'd0);
    @(negedge CLK); RST = 1'b0;

    // Data-memory miss held for three cycles
    @(negedge CLK); dmemREN = 1'b1; dhit = 1'b0; #1;
    check_eq("dw_c1_stall", stall_a, 4'hF);
    check_eq("dw_c1_pc",    pc_a,    1'b1);
    check_eq("dw_c1_flush", flush_a, 4'h0);
    check_eq("dw_c1_state", state_a, 2'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      check_eq("dw_state", state_a, 2'd1);
      check_eq("dw_stall", stall_a, 4'hF);
    end
    @(negedge CLK); dhit = 1'b1; #1;
    check_eq("dw_hit_stall", stall_a, 4'h0);
    check_eq("dw_hit_pc",    pc_a,    1'b0);
    check_eq("dw_cnt",       cnt_a,   16'd3);
    @(negedge CLK); idle(); #1;
    check_eq("dw_exit_state", state_a, 2'd0);
    check_eq("dw_exit_cnt",   cnt_a,   16'd3);

    // Redirect arriving mid data-wait is deferred to the dhit cycle
    do_reset();
    @(negedge CLK); dmemREN = 1'b1; dhit = 1'b0;
    @(negedge CLK);
    @(negedge CLK); redirect = 1'b1; #1;
    check_eq("pr_redir_flush", flush_a, 4'h0);
    check_eq("pr_redir_stall", stall_a, 4'hF);
    @(negedge CLK); redirect = 1'b0; #1;
    check_eq("pr_pend",        dut_a.r_pend_redir, 1'b1);
    check_eq("pr_wait_flush",  flush_a, 4'h0);
    @(negedge CLK); dhit = 1'b1; #1;
    check_eq("pr_hit_flush",   flush_a, 4'h3);
    check_eq("pr_hit_stall",   stall_a, 4'h0);
    check_eq("pr_hit_pc",      pc_a,    1'b0);
    @(negedge CLK); idle(); ihit = 1'b0; #1;
    check_eq("pr_redir_state", state_a, 2'd3);
    check_eq("pr_redir_f0",    flush_a, 4'h1);
    check_eq("pr_redir_pc",    pc_a,    1'b0);
    check_eq("pr_pend_clr",    dut_a.r_pend_redir, 1'b0);
    @(negedge CLK); ihit = 1'b1; #1;
    check_eq("pr_redir_hold",  state_a, 2'd3);
    @(negedge CLK); #1;
    check_eq("pr_back_run",    state_a, 2'd0);
    check_eq("pr_back_flush",  flush_a, 4'h0);

    // Load-use: one bubble with forwarding, continuous stall without
    do_reset();
    @(negedge CLK); idex_memread = 1'b1; idex_rd = 5'd8; ifid_rt = 5'd8; #1;
    check_eq("lu_pc",    pc_a,    1'b1);
    check_eq("lu_stall", stall_a, 4'h1);
    check_eq("lu_flush", flush_a, 4'h2);
    check_eq("lu_nf_pc", pc_n,    1'b1);
    @(negedge CLK); #1;
    check_eq("lu_state",    state_a, 2'd2);
    check_eq("lu_2nd_pc",   pc_a,    1'b0);
    check_eq("lu_2nd_fl",   flush_a, 4'h0);
    check_eq("lu_nf_state", state_n, 2'd0);
    check_eq("lu_nf_2nd",   pc_n,    1'b1);
    @(negedge CLK); idle(); idex_memread = 1'b1; #1;
    check_eq("lu_r0_state", state_a, 2'd0);
    check_eq("lu_r0_pc",    pc_a,    1'b0);
    check_eq("lu_r0_nf_pc", pc_n,    1'b0);

    // No forwarding: stall until the producer leaves MEM/WB
    do_reset();
    @(negedge CLK); exmem_rd = 5'd9; exmem_regwr = 1'b1; ifid_rs = 5'd9; #1;
    check_eq("nf_ex_pc",    pc_n,    1'b1);
    check_eq("nf_ex_stall", stall_n, 4'h1);
    check_eq("nf_ex_flush", flush_n, 4'h2);
    check_eq("nf_fwd_pc",   pc_a,    1'b0);
    @(negedge CLK); exmem_rd = '0; exmem_regwr = 1'b0; memwb_rd = 5'd9; memwb_regwr = 1'b1; #1;
    check_eq("nf_wb_pc",    pc_n,    1'b1);
    check_eq("nf_wb_state", state_n, 2'd0);
    @(negedge CLK); memwb_regwr = 1'b0; #1;
    check_eq("nf_done_pc",  pc_n,    1'b0);

    // Fetch-miss stalls and counter saturation
    do_reset();
    @(negedge CLK); ihit = 1'b0; #1;
    check_eq("im_pc",    pc_a,    1'b1);
    check_eq("im_stall", stall_a, 4'h1);
    check_eq("im_flush", flush_a, 4'h2);
    repeat (19) @(negedge CLK);
    @(negedge CLK); ihit = 1'b1; #1;
    check_eq("sat_cnt4",  cnt_c, 4'hF);
    check_eq("cnt16_20",  cnt_a, 16'd20);
    check_eq("im_end_pc", pc_a,  1'b0);

    // Priority: redirect beats load-use and fetch miss; data wait beats redirect
    do_reset();
    @(negedge CLK); redirect = 1'b1; ihit = 1'b0;
    idex_memread = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8; #1;
    check_eq("pri_rd_flush", flush_a, 4'h3);
    check_eq("pri_rd_pc",    pc_a,    1'b0);
    check_eq("pri_rd_stall", stall_a, 4'h0);
    @(negedge CLK); idle();
    @(negedge CLK); dmemWEN = 1'b1; dhit = 1'b0; redirect = 1'b1; #1;
    check_eq("pri_dw_state", state_a, 2'd0);
    check_eq("pri_dw_stall", stall_a, 4'hF);
    check_eq("pri_dw_flush", flush_a, 4'h0);

    // Asynchronous reset mid data-wait discards the pending redirect
    do_reset();
    @(negedge CLK); dmemREN = 1'b1; dhit = 1'b0;
    @(negedge CLK); redirect = 1'b1;
    @(negedge CLK); redirect = 1'b0; #1;
    check_eq("ar_pend_set", dut_a.r_pend_redir, 1'b1);
    check_eq("ar_state_dw", state_a, 2'd1);
    #2 RST = 1'b1; #1;
    check_eq("ar_state", state_a, 2'd0);
    check_eq("ar_pend",  dut_a.r_pend_redir, 1'b0);
    check_eq("ar_cnt",   cnt_a,   16'd0);
    check_eq("ar_flush", flush_a, 4'hF);
    check_eq("ar_stall", stall_a, 4'h0);
    @(negedge CLK); idle(); RST = 1'b0; #1;
    check_eq("ar_rel_flush", flush_a, 4'h0);
    @(negedge CLK); #1;
    check_eq("ar_rel2_flush", flush_a, 4'h0);
    check_eq("ar_rel2_state", state_a, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
